pudding_serial_host: RTL and testbench
======================================

Name: pudding_serial_host

Overview:
- Host-side initiator for the DAC chip's serial load interface: datum, shift, transfer, dir, enable and a readback bit.
- Serialises a WIDTH-bit source-enable word into the on-chip daisychain and commits it to the DAC state register (write).
- Loads the state register back into the chain and shifts it out, recirculating each bit so the chain is restored (read).
- Sits in the FPGA/test-controller fabric on the same clock as the chip; its outputs drive the chip's ui_in[4:0] and ser_rx is fed from uo_out[7].

Parameters:
WIDTH, 128, length of daisychain/state register in bits
GAP, 1, idle cycles after every strobe (0..15); read ops require GAP>=1

Ports:
clk  input  1  clock, shared with chip
rst_n  input  1  asynchronous active-low reset
start  input  1  begin operation; accepted only in IDLE
op  input  1  1=write (commit tx_data), 0=read (capture state)
tx_data  input  WIDTH  word to write; captured on accepted start
dac_en  input  1  requested DAC enable level
busy  output  1  high from cycle after accepted start until done cycle inclusive
done  output  1  one-cycle pulse at operation end
rx_data  output  WIDTH  last read result; updated only at read done
ser_datum  output  1  serial data bit (chip ui_in[0])
ser_shift  output  1  shift strobe (ui_in[1])
ser_transfer  output  1  transfer strobe (ui_in[2])
ser_dir  output  1  transfer direction (ui_in[3]): 1=chain->state, 0=state->chain
ser_en  output  1  DAC enable (ui_in[4])
ser_rx  input  1  chain MSB readback (uo_out[7])

Behaviour:
- Reset (async, rst_n=0): all outputs 0, rx_data=0, FSM IDLE, counters 0; any in-flight op is aborted with no done pulse.
- All ser_* outputs are registered. ser_en = dac_en delayed by one cycle, independent of the FSM.
- FSM states: IDLE, LOAD, SHIFT, COMMIT, GAP, FIN.
- IDLE + start: capture tx_data and op; set busy next cycle.
  - op=1 -> SHIFT.
  - op=0 -> LOAD.
- Strobes:
  - Each strobe is exactly one cycle with exactly one of ser_shift/ser_transfer high.
  - Every strobe is followed by GAP cycles with both strobes low.
  - ser_shift and ser_transfer are never high together.
- LOAD (read only): ser_transfer=1, ser_dir=0. Then GAP, then SHIFT.
- SHIFT, write: strobe k (k=0..WIDTH-1) drives ser_datum = tx_data[WIDTH-1-k], MSB first. After the last shift -> COMMIT.
- COMMIT (write only): ser_transfer=1, ser_dir=1. Then GAP, then FIN.
- SHIFT, read:
  - ser_rx is registered on the last GAP cycle preceding shift strobe j (j=0..WIDTH-1).
  - That sample is driven on ser_datum during strobe j (recirculation) and stored in shadow bit WIDTH-1-j.
  - After the last shift and its GAP -> FIN.
- FIN: done=1 for one cycle. On a read, rx_data <= shadow in the same cycle. busy=1 in FIN, 0 on the next cycle. FSM returns to IDLE.
- Timing (start accepted at cycle N):
  - Strobe i occurs at N+1+i*(GAP+1), i=0..WIDTH.
  - done occurs at N+1+(WIDTH+1)*(GAP+1).
  - WIDTH=128, GAP=1: done at N+259.
- Outside transfer strobes, ser_dir holds the op value and ser_datum holds its last driven value.
- start while busy: ignored, with no effect on tx_data capture or the op.
- Read with GAP=0: behaviour unspecified; guarded by an elaboration-time assertion.
- tx_data changes after capture have no effect. dac_en changes during an op propagate normally.

Test Plan:
1. Write, WIDTH=128, GAP=1, tx_data=128'h8000...0001, bench chip model -> shift strobes at N+1,N+3,...,N+255; ser_datum=1 on first and last; transfer+dir=1 at N+257; done at N+259; model state=8000...0001.
2. Read after test 1, model state=128'hA5A5...A5A5 -> transfer dir=0 at N+1; rx_data=A5A5...A5A5 at done; model chain equals state after op (recirculation).
3. Write with GAP=0, tx_data=all ones -> 128 back-to-back shift cycles N+1..N+128; commit at N+129; done at N+130; state=all ones.
4. start pulsed at every cycle during a write with changing tx_data -> only first word committed; single done pulse.
5. rst_n low at strobe 40 of a read -> outputs 0 immediately, rx_data=0, no done; a new read started after release completes correctly.
6. dac_en toggled 0->1->0 in IDLE and mid-op -> ser_en follows with exactly one-cycle latency; FSM timing unchanged.

Source files
------------

// File: rtl/pudding_serial_if.sv
// pudding_serial_if: serial load bus between the host and the DAC chip
//   datum    : serial data bit            (chip ui_in[0])
//   shift    : daisychain shift strobe    (chip ui_in[1])
//   transfer : chain/state transfer strobe (chip ui_in[2])
//   dir      : 1=chain->state, 0=state->chain (chip ui_in[3])
//   en       : DAC enable                 (chip ui_in[4])
//   rx       : chain MSB readback         (chip uo_out[7])
interface pudding_serial_if;
  logic datum, shift, transfer, dir, en, rx;
  modport master (output datum, shift, transfer, dir, en, input rx);
  modport slave (input datum, shift, transfer, dir, en, output rx);
endinterface

// File: rtl/pudding_serial_host.sv
// pudding_serial_host: host-side initiator that writes/reads the DAC chip state register over its serial load bus
//   clk, rst_n        : shared chip clock, asynchronous active-low reset
//   start, op         : begin an operation (1=write tx_data, 0=read state) when idle
//   tx_data, dac_en   : word to commit, requested DAC enable level
//   busy, done        : operation in progress, one-cycle completion pulse
//   rx_data           : result of the last completed read
//   ser               : registered serial bus toward the chip (master side)
module pudding_serial_host #(
  parameter int WIDTH = 128,
  parameter int GAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             dac_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  pudding_serial_if.master ser
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, COMMIT, GAP_ST, FIN} state_t;
  state_t state, state_d, dest, dest_d, after;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0] gcnt, gcnt_d;
  logic [WIDTH-1:0] data_q, data_d, src;
  logic op_q, opn, acc, datum_d;
  if (GAP < 0 || GAP > 15) begin : g_gap_range
    $error("GAP must be within 0..15");
  end
  if (GAP == 0) begin : g_no_read
    always_ff @(posedge clk)
      assert (!(state == IDLE && start && !op)) else $error("read requires GAP >= 1");
  end
  // data_q doubles as the write source (rotated MSB first) and the read shadow
  // (samples enter at the LSB, so the first sample ends up in the MSB).
  always_comb begin
    acc = state == IDLE && start;
    opn = acc ? op : op_q;
    src = acc ? tx_data : data_q;
    after = state == LOAD ? SHIFT : state == COMMIT ? FIN :
            cnt != CW'(WIDTH) ? SHIFT : op_q ? COMMIT : FIN;
    state_d = state;
    dest_d = dest;
    gcnt_d = gcnt;
    case (state)
      IDLE: state_d = start ? (op ? SHIFT : LOAD) : IDLE;
      LOAD, SHIFT, COMMIT: begin
        state_d = GAP == 0 ? after : GAP_ST;
        dest_d = after;
        gcnt_d = 4'(GAP - 1);
      end
      GAP_ST: begin
        state_d = gcnt == 4'd0 ? dest : GAP_ST;
        gcnt_d = gcnt - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state == IDLE ? '0 : cnt) + CW'(state_d == SHIFT);
    // on a read, the bit sampled now is recirculated into the chain by this shift
    datum_d = state_d == SHIFT ? (opn ? src[WIDTH-1] : ser.rx) : ser.datum;
    data_d = state_d == SHIFT ? {src[WIDTH-2:0], datum_d} : src;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dest <= IDLE;
      cnt <= '0;
      gcnt <= '0;
      data_q <= '0;
      op_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rx_data <= '0;
      ser.datum <= 1'b0;
      ser.shift <= 1'b0;
      ser.transfer <= 1'b0;
      ser.dir <= 1'b0;
      ser.en <= 1'b0;
    end else begin
      state <= state_d;
      dest <= dest_d;
      cnt <= cnt_d;
      gcnt <= gcnt_d;
      data_q <= data_d;
      op_q <= opn;
      busy <= state_d != IDLE;
      done <= state_d == FIN;
      if (state_d == FIN && !op_q) rx_data <= data_q;
      ser.datum <= datum_d;
      ser.shift <= state_d == SHIFT;
      ser.transfer <= state_d == LOAD || state_d == COMMIT;
      ser.dir <= opn;
      ser.en <= dac_en;
    end
  end
endmodule

// File: tb/tb_pudding_serial_host.sv
// tb_pudding_serial_host: directed bench with a chip daisychain model for GAP=1 and GAP=0 hosts
module tb_pudding_serial_host;
  localparam int W = 128;
  localparam logic [W-1:0] T1 = {1'b1, 126'd0, 1'b1};
  localparam logic [W-1:0] A5 = {16{8'hA5}};
  localparam logic [W-1:0] W4 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [W-1:0] W6 = {4{32'hDEADBEEF}};
  logic clk = 1'b0, rst_n = 1'b0;
  logic start [2], op_i [2], dac_en [2], busy [2], done [2];
  logic [W-1:0] txd [2], rxd [2];
  int cyc = 0, checks = 0, errors = 0;
  pudding_serial_if s0 ();
  pudding_serial_if s1 ();
  pudding_serial_host #(.WIDTH(W), .GAP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .op(op_i[0]), .tx_data(txd[0]),
    .dac_en(dac_en[0]), .busy(busy[0]), .done(done[0]), .rx_data(rxd[0]), .ser(s0));
  pudding_serial_host #(.WIDTH(W), .GAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .op(op_i[1]), .tx_data(txd[1]),
    .dac_en(dac_en[1]), .busy(busy[1]), .done(done[1]), .rx_data(rxd[1]), .ser(s1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] chain0 = '0, state0 = '0, chain1 = '0, state1 = '0, pre_val = '0;
  logic pre_en = 1'b0;
  assign s0.rx = chain0[W-1];
  assign s1.rx = chain1[W-1];
  always @(posedge clk) begin
    if (s0.shift) chain0 <= {chain0[W-2:0], s0.datum};
    if (s0.transfer && !s0.dir) chain0 <= state0;
    if (s0.transfer && s0.dir) state0 <= chain0;
    if (pre_en) state0 <= pre_val;
    if (s1.shift) chain1 <= {chain1[W-2:0], s1.datum};
    if (s1.transfer && !s1.dir) chain1 <= state1;
    if (s1.transfer && s1.dir) state1 <= chain1;
  end

  logic sh [2], tr [2], dr [2], dt [2];
  assign sh[0] = s0.shift;
  assign tr[0] = s0.transfer;
  assign dr[0] = s0.dir;
  assign dt[0] = s0.datum;
  assign sh[1] = s1.shift;
  assign tr[1] = s1.transfer;
  assign dr[1] = s1.dir;
  assign dt[1] = s1.datum;
  int sh_n [2], sh_first [2], sh_last [2], ones [2], tr_n [2], tr_cyc [2], dn_n [2], dn_cyc [2], bad [2], n0 [2];
  logic d_first [2], d_last [2], tr_dir [2], bz_done [2];
  bit clr [2];

  function automatic int relc(input int u);
    return cyc - n0[u];
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (clr[u]) begin
        sh_n[u] <= 0; sh_first[u] <= 0; sh_last[u] <= 0; ones[u] <= 0; tr_n[u] <= 0;
        tr_cyc[u] <= 0; dn_n[u] <= 0; dn_cyc[u] <= 0; bad[u] <= 0;
        d_first[u] <= 1'b0; d_last[u] <= 1'b0; tr_dir[u] <= 1'b0; bz_done[u] <= 1'b0;
      end else begin
        bad[u] <= bad[u] + int'(sh[u] && tr[u]) +
                  int'((sh[u] || tr[u]) && ((relc(u) - 1) % (u == 0 ? 2 : 1)) != 0);
        if (sh[u]) begin
          if (sh_n[u] == 0) begin
            sh_first[u] <= relc(u);
            d_first[u] <= dt[u];
          end
          sh_last[u] <= relc(u);
          d_last[u] <= dt[u];
          sh_n[u] <= sh_n[u] + 1;
          ones[u] <= ones[u] + int'(dt[u]);
        end
        if (tr[u]) begin
          tr_n[u] <= tr_n[u] + 1;
          tr_cyc[u] <= relc(u);
          tr_dir[u] <= dr[u];
        end
        if (done[u]) begin
          dn_n[u] <= dn_n[u] + 1;
          dn_cyc[u] <= relc(u);
          bz_done[u] <= busy[u];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int u, input logic o, input logic [W-1:0] d, input bit hold);
    @(posedge clk); #1;
    clr[u] = 1'b1;
    @(posedge clk); #1;
    clr[u] = 1'b0;
    start[u] = 1'b1;
    op_i[u] = o;
    txd[u] = d;
    n0[u] = cyc;
    @(posedge clk); #1;
    chk("busy_rise", busy[u], 1);
    if (!hold) start[u] = 1'b0;
    for (int i = 0; i < 400 && dn_n[u] == 0; i++) begin
      if (hold) begin
        txd[u] = {$urandom, $urandom, $urandom, $urandom};
        op_i[u] = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    start[u] = 1'b0;
    @(posedge clk); #1;
    chk("busy_fall", busy[u], 0);
  endtask

  task automatic checkop(input string t, input int u, input int sf, input int sl, input int tc,
                         input logic td, input int dc, input int on, input logic df, input logic dl);
    chk({t, "_shifts"}, sh_n[u], 128);
    chk({t, "_first_shift"}, sh_first[u], sf);
    chk({t, "_last_shift"}, sh_last[u], sl);
    chk({t, "_first_bit"}, d_first[u], df);
    chk({t, "_last_bit"}, d_last[u], dl);
    chk({t, "_ones"}, ones[u], on);
    chk({t, "_xfers"}, tr_n[u], 1);
    chk({t, "_xfer_cyc"}, tr_cyc[u], tc);
    chk({t, "_xfer_dir"}, tr_dir[u], td);
    chk({t, "_dones"}, dn_n[u], 1);
    chk({t, "_done_cyc"}, dn_cyc[u], dc);
    chk({t, "_grid"}, bad[u], 0);
    chk({t, "_busy_at_done"}, bz_done[u], 1);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; op_i[u] = 1'b0; dac_en[u] = 1'b0; txd[u] = '0; clr[u] = 1'b0; n0[u] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {s0.datum, s0.shift, s0.transfer, s0.dir, s0.en, busy[0], done[0]}, 0);
    chk("rst_rx", rxd[0], 0);
    rst_n = 1'b1;
    // write 8000...0001 with GAP=1
    run(0, 1'b1, T1, 1'b0);
    checkop("t1", 0, 1, 255, 257, 1'b1, 259, 2, 1'b1, 1'b1);
    chk("t1_state", state0, T1);
    // read back a preloaded A5 pattern; chain must be restored
    @(posedge clk); #1;
    pre_val = A5;
    pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
    run(0, 1'b0, '0, 1'b0);
    checkop("t2", 0, 3, 257, 1, 1'b0, 259, 64, 1'b1, 1'b1);
    chk("t2_rx", rxd[0], A5);
    chk("t2_chain", chain0, A5);
    chk("t2_state", state0, A5);
    // back-to-back shifts with GAP=0
    run(1, 1'b1, '1, 1'b0);
    checkop("t3", 1, 1, 128, 129, 1'b1, 130, 128, 1'b1, 1'b1);
    chk("t3_state", state1, '1);
    // start held every cycle with changing data and op
    run(0, 1'b1, W4, 1'b1);
    checkop("t4", 0, 1, 255, 257, 1'b1, 259, 64, 1'b0, 1'b0);
    chk("t4_state", state0, W4);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_single_done", dn_n[0], 1);
    // reset in the middle of a read at strobe 40
    @(posedge clk); #1;
    clr[0] = 1'b1;
    @(posedge clk); #1;
    clr[0] = 1'b0;
    start[0] = 1'b1;
    op_i[0] = 1'b0;
    n0[0] = cyc;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("t5_strobe40", s0.shift, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outputs", {s0.datum, s0.shift, s0.transfer, s0.dir, s0.en, busy[0], done[0]}, 0);
    chk("t5_rst_rx", rxd[0], 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_done", dn_n[0], 0);
    run(0, 1'b0, '0, 1'b0);
    checkop("t5", 0, 3, 257, 1, 1'b0, 259, 64, 1'b0, 1'b0);
    chk("t5_rx", rxd[0], W4);
    chk("t5_chain", chain0, W4);
    // dac_en latency while idle
    @(posedge clk); #1;
    dac_en[0] = 1'b1;
    chk("t6_idle_lag_hi", s0.en, 0);
    @(posedge clk); #1;
    chk("t6_idle_rise", s0.en, 1);
    dac_en[0] = 1'b0;
    chk("t6_idle_lag_lo", s0.en, 1);
    @(posedge clk); #1;
    chk("t6_idle_fall", s0.en, 0);
    // dac_en latency during a write
    fork
      run(0, 1'b1, W6, 1'b0);
      begin
        repeat (20) @(posedge clk);
        #1;
        dac_en[0] = 1'b1;
        chk("t6_op_lag_hi", s0.en, 0);
        @(posedge clk); #1;
        chk("t6_op_rise", s0.en, 1);
        repeat (10) @(posedge clk);
        #1;
        dac_en[0] = 1'b0;
        chk("t6_op_lag_lo", s0.en, 1);
        @(posedge clk); #1;
        chk("t6_op_fall", s0.en, 0);
      end
    join
    checkop("t6", 0, 1, 255, 257, 1'b1, 259, 96, 1'b1, 1'b1);
    chk("t6_state", state0, W6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
